// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences an external DEPTH-stage serial shift register
// for one word transfer: clear, shift WIDTH bits in (MSB- or LSB-first),
// flush, and collect the bits from the register output into rx_data.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   tx_data/tx_lsb_first/tx_valid/tx_ready   parallel word in (handshake)
//   hold                pauses shifting while in SHIFT
//   sr_in/sr_enable/sr_clear/sr_out          shift-register datapath
//   rx_data/rx_valid/rx_ready                reassembled word out (handshake)
//   busy                high in any state other than IDLE
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_lsb_first,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             hold,
    output logic             sr_in,
    output logic             sr_enable,
    output logic             sr_clear,
    input  logic             sr_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH + WIDTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_LAST  = CW'(DEPTH + WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              lsb_q, lsb_d;
    logic [WIDTH-1:0]  rx_q, rx_d;

    logic [WIDTH-1:0]  tx_rev;
    logic [WIDTH-1:0]  ord_mask;
    logic [WIDTH-1:0]  ord_rev;
    logic [WIDTH-1:0]  pos_mask;

    // word_q holds the latched word already in transmit order; it is
    // shifted right once per unpaused SHIFT cycle, so bit 0 is always the
    // next bit to send and zeros fill in naturally for the flush phase.
    assign tx_rev = {<<{tx_data}};

    // One-hot receive mask in order space, mapped back to bit position.
    assign ord_mask = WIDTH'(1) << (cnt_q - C_DEPTH);
    assign ord_rev  = {<<{ord_mask}};
    assign pos_mask = lsb_q ? ord_mask : ord_rev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            lsb_q   <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            lsb_q   <= lsb_d;
            rx_q    <= rx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        lsb_d     = lsb_q;
        rx_d      = rx_q;
        tx_ready  = 1'b0;
        sr_in     = 1'b0;
        sr_enable = 1'b0;
        sr_clear  = 1'b0;
        rx_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    word_d  = tx_lsb_first ? tx_data : tx_rev;
                    lsb_d   = tx_lsb_first;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                sr_clear  = 1'b1;
                sr_enable = 1'b1;
                cnt_d     = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                sr_enable = ~hold;
                sr_in     = word_q[0];
                if (!hold) begin
                    word_d = word_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    // First bit reaches the register output DEPTH cycles
                    // after it was driven.
                    if (cnt_q >= C_DEPTH) begin
                        rx_d = (rx_q & ~pos_mask)
                             | (sr_out ? pos_mask : '0);
                    end
                    if (cnt_q == C_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rx_valid = 1'b1;
                if (rx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_data = rx_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioral shift registers in loopback,
// expected words queued at accept and checked by decoupled monitors.
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int W2 = 4;
    localparam int D2 = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] tx_data = '0;
    logic [W-1:0] rx_data;
    logic tx_lsb_first = 1'b0, tx_valid = 1'b0, hold = 1'b0;
    logic rx_ready = 1'b1;
    logic tx_ready, sr_in, sr_enable, sr_clear, sr_out, rx_valid, busy;
    logic [D-1:0] sr = '0;

    logic [W2-1:0] tx2_data = '0;
    logic [W2-1:0] rx2_data;
    logic tx2_lsb = 1'b0, tx2_valid = 1'b0;
    logic tx2_ready, sr2_in, sr2_enable, sr2_clear, sr2_out;
    logic rx2_valid, busy2;
    logic [D2-1:0] sr2 = '0;

    shift_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_lsb_first(tx_lsb_first),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .hold(hold),
        .sr_in(sr_in), .sr_enable(sr_enable),
        .sr_clear(sr_clear), .sr_out(sr_out),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy)
    );

    shift_sequencer #(.WIDTH(W2), .DEPTH(D2)) dut2 (
        .clk(clk), .reset(reset),
        .tx_data(tx2_data), .tx_lsb_first(tx2_lsb),
        .tx_valid(tx2_valid), .tx_ready(tx2_ready),
        .hold(1'b0),
        .sr_in(sr2_in), .sr_enable(sr2_enable),
        .sr_clear(sr2_clear), .sr_out(sr2_out),
        .rx_data(rx2_data), .rx_valid(rx2_valid),
        .rx_ready(1'b1), .busy(busy2)
    );

    always @(posedge clk) begin
        if (sr_clear) sr <= '0;
        else if (sr_enable) sr <= (sr << 1) | D'(sr_in);
        if (sr2_clear) sr2 <= '0;
        else if (sr2_enable) sr2 <= (sr2 << 1) | D2'(sr2_in);
    end
    assign sr_out  = sr[D-1];
    assign sr2_out = sr2[D2-1];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [W-1:0] d;
        int e;
    } exp_t;
    exp_t q[$];
    exp_t q2[$];
    logic pv = 1'b0;
    logic pv2 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, a, e, cyc);
        end
    endtask

    // Monitor for the 8x8 instance
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rx_valid) begin
                if (q.size() == 0) begin
                    chk("rx_unexpected", 32'(rx_valid), 0);
                end else begin
                    if (!pv) chk("rx_edge", cyc, q[0].e);
                    chk("rx_data", 32'(rx_data), 32'(q[0].d));
                    if (rx_ready) void'(q.pop_front());
                end
            end
            pv = rx_valid;
        end
    end

    // Monitor for the DEPTH=1, WIDTH=4 instance
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rx2_valid) begin
                if (q2.size() == 0) begin
                    chk("rx2_unexpected", 32'(rx2_valid), 0);
                end else begin
                    if (!pv2) chk("rx2_edge", cyc, q2[0].e);
                    chk("rx2_data", 32'(rx2_data), 32'(q2[0].d));
                    void'(q2.pop_front());
                end
            end
            pv2 = rx2_valid;
        end
    end

    // Returns at the negedge inside the CLEAR cycle.
    task automatic send(input logic [W-1:0] d, input logic lsb,
                        input bit push, input int extra);
        int n;
        @(negedge clk);
        tx_data = d;
        tx_lsb_first = lsb;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("tx_accept_timeout", 0, 1);
        if (push) q.push_back('{d, cyc + 1 + D + W + 1 + extra});
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = '0;
    endtask

    task automatic send2(input logic [W2-1:0] d, input logic lsb);
        int n;
        @(negedge clk);
        tx2_data = d;
        tx2_lsb = lsb;
        tx2_valid = 1'b1;
        n = 0;
        while (!tx2_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx2_ready) chk("tx2_accept_timeout", 0, 1);
        q2.push_back('{W'(d), cyc + 1 + D2 + W2 + 1});
        @(negedge clk);
        tx2_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !tx_ready || q2.size() != 0
                || !tx2_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq;
        logic hv;
        int n;

        // Reset state
        #12;
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_sr_enable", 32'(sr_enable), 0);
        chk("rst_sr_clear", 32'(sr_clear), 0);
        chk("rst_sr_in", 32'(sr_in), 0);
        @(negedge clk);
        reset = 1'b1;

        // A5 MSB-first loopback: check CLEAR and the sr_in stream
        send(8'hA5, 1'b0, 1'b1, 0);
        chk("clr_sr_clear", 32'(sr_clear), 1);
        chk("clr_sr_enable", 32'(sr_enable), 1);
        chk("clr_sr_in", 32'(sr_in), 0);
        chk("clr_tx_ready", 32'(tx_ready), 0);
        chk("clr_busy", 32'(busy), 1);
        seq = 16'b1010_0101_0000_0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("a5_sr_in", 32'(sr_in), 32'(seq[15-i]));
            chk("a5_sr_enable", 32'(sr_enable), 1);
            chk("a5_tx_ready", 32'(tx_ready), 0);
        end
        wait_idle();
        chk("a5_valid_drop", 32'(rx_valid), 0);

        // 01 LSB-first: a single leading one
        send(8'h01, 1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lsb_sr_in", 32'(sr_in), (i == 0) ? 1 : 0);
        end
        wait_idle();

        // Hold for 3 cycles at c = 5; 5C MSB-first sends bit 2 (=1) there
        send(8'h5C, 1'b0, 1'b1, 3);
        @(negedge clk);
        repeat (5) @(negedge clk);
        hold = 1'b1;
        #1;
        hv = sr_in;
        chk("hold_sr_in_val", 32'(hv), 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_sr_enable", 32'(sr_enable), 0);
            chk("hold_sr_in", 32'(sr_in), 32'(hv));
            @(negedge clk);
        end
        hold = 1'b0;
        wait_idle();

        // rx_ready stall in DONE
        rx_ready = 1'b0;
        send(8'h96, 1'b0, 1'b1, 0);
        n = 0;
        while (!rx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) chk("stall_valid_timeout", 0, 1);
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_tx_ready", 32'(tx_ready), 0);
            chk("stall_rx_valid", 32'(rx_valid), 1);
            chk("stall_rx_data", 32'(rx_data), 32'h96);
        end
        tx_valid = 1'b0;
        tx_data = '0;
        rx_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_exit_valid", 32'(rx_valid), 0);
        chk("stall_exit_tx_ready", 32'(tx_ready), 1);
        chk("stall_exit_busy", 32'(busy), 0);
        wait_idle();

        // Reset mid-SHIFT at c = 10 aborts with no rx_valid
        send(8'hFF, 1'b0, 1'b0, 0);
        @(negedge clk);
        repeat (10) @(negedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sr_enable", 32'(sr_enable), 0);
        chk("abort_sr_clear", 32'(sr_clear), 0);
        chk("abort_tx_ready", 32'(tx_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        send(8'h3C, 1'b0, 1'b1, 0);
        wait_idle();

        // DEPTH = 1, WIDTH = 4
        send2(4'b1001, 1'b0);
        wait_idle();
        send2(4'b0011, 1'b1);
        wait_idle();
        send2(4'b0110, 1'b0);
        wait_idle();

        chk("q_empty", q.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller that sequences a single-bit serial shift register (DEPTH stages, external to this block) for a word transfer. It accepts a parallel word over a valid/ready handshake, clears the register, and shifts the word in bit-serially, MSB-first or LSB-first. It collects the bits emerging from the register's serial output and presents the reassembled word over a second valid/ready handshake. It sits between a parallel word source/sink and the shift-register datapath, and is used both for loopback self-test of the register and for word-level delay lines.

## Interface
Parameters:
- WIDTH, 8, bits per transferred word (>=1)
- DEPTH, 8, number of stages in the attached shift register (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- tx_data  input  WIDTH  word to send; sampled on accept
- tx_lsb_first  input  1  bit order, sampled on accept: 1 = bit 0 first, 0 = bit WIDTH-1 first
- tx_valid  input  1  source has a word
- tx_ready  output  1  block can accept a word
- hold  input  1  pauses shifting while 1 (SHIFT state only)
- sr_in  output  1  serial data to the register input
- sr_enable  output  1  shift enable to the register
- sr_clear  output  1  synchronous active-high clear to the register
- sr_out  input  1  register serial output (last stage)
- rx_data  output  WIDTH  reassembled word
- rx_valid  output  1  rx_data is valid
- rx_ready  input  1  sink accepts rx_data
- busy  output  1  1 in any state other than IDLE

## Operation
- States: IDLE, CLEAR, SHIFT, DONE. Reset (reset=0) forces IDLE immediately. Counter = 0. rx_data = 0. Order flag = 0. All outputs are 0 except tx_ready = 1.
- IDLE:
  - tx_ready = 1.
  - Accept when tx_valid & tx_ready.
  - On accept, latch tx_data and tx_lsb_first, then go to CLEAR.
- CLEAR: lasts exactly 1 cycle.
  - sr_clear = 1, sr_enable = 1, sr_in = 0.
  - hold is ignored.
  - Counter c is set to 0, then go to SHIFT.
- SHIFT: lasts DEPTH+WIDTH unpaused cycles, indexed by c = 0..DEPTH+WIDTH-1.
  - sr_enable = ~hold.
  - For c < WIDTH, sr_in = bit c of the latched word in transmit order. Order index k maps to bit k if LSB-first, else bit WIDTH-1-k.
  - For c >= WIDTH, sr_in = 0 (flush).
  - For DEPTH <= c <= DEPTH+WIDTH-1, at the closing edge of an unpaused cycle, sample sr_out into rx_data at the bit for order index c-DEPTH, using the same mapping as tx.
  - When hold = 1: c is frozen, nothing is sampled, and sr_in keeps its current value.
  - After the unpaused cycle with c = DEPTH+WIDTH-1, go to DONE.
- DONE:
  - rx_valid = 1 and rx_data is held stable until rx_ready = 1. On that edge, go to IDLE.
  - tx_ready = 0 in DONE, so no new accept is possible in the same cycle.
- For an ideal register model, rx_data equals the accepted tx_data.
- rx_data keeps its last value after DONE. Bits are overwritten individually during the next SHIFT.
- Reset mid-operation (any state) aborts the transfer:
  - No rx_valid is produced.
  - sr_enable and sr_clear drop to 0 asynchronously.
  - The next transfer re-clears the register via CLEAR.

## Timing
- All state changes happen on the rising clk edge, except reset, which acts asynchronously. Reset release is synchronized by the user.
- Outputs sr_in, sr_enable, sr_clear, tx_ready, rx_valid and busy are decoded from registered state and counter. There is no combinational path from tx_valid or rx_ready to any output.
- Accept edge = edge 0. CLEAR occupies cycle 0→1. SHIFT covers edges 2..DEPTH+WIDTH+1.
- rx_valid rises after edge DEPTH+WIDTH+1 with hold = 0. With defaults this is edge 17.
- Each cycle that hold = 1 in SHIFT adds one cycle of latency.
- Sampling assumption: a bit driven during cycle j appears on sr_out during cycle j+DEPTH.
- Minimum transfer period with rx_ready tied high: DEPTH+WIDTH+3 cycles, accept to next accept.
- Boundary, WIDTH = 1 or DEPTH = 1: the same rules apply, and SHIFT has DEPTH+WIDTH cycles.
- Counter width: $clog2(DEPTH+WIDTH+1) bits.

## Test plan
- Loopback with a behavioral 8-stage register, tx_data = 8'hA5, MSB-first, rx_ready = 1 → sr_in sequence 1,0,1,0,0,1,0,1, then eight 0s. rx_valid is high for 1 cycle at edge 17 with rx_data = 8'hA5. tx_ready = 0 from edge 1 until IDLE is re-entered.
- Same loopback, tx_data = 8'h01, tx_lsb_first = 1 → first sr_in bit = 1 and the remaining seven = 0. rx_data = 8'h01.
- hold = 1 for 3 cycles at SHIFT c = 5 → sr_enable = 0 and c frozen during those cycles. rx_valid is delayed to edge 20 and rx_data is still correct.
- rx_ready = 0 for 4 cycles after rx_valid rises → rx_valid and rx_data stay stable, tx_valid is not accepted, and IDLE is entered on the edge where rx_ready = 1.
- reset = 0 pulse mid-SHIFT (c = 10) → busy = 0, sr_enable = 0 and tx_ready = 1 immediately, with no rx_valid. A new transfer of 8'h3C then completes with rx_data = 8'h3C.
- DEPTH = 1, WIDTH = 4, tx_data = 4'b1001 → rx_valid after edge 6 with rx_data = 4'b1001.
